// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store, flush/hold and memory-port signals of mem_arbiter.
// slave is the arbiter side; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              ls_req_i;
    logic              ls_we_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic [STRB_W-1:0] ls_wstrb_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;

    logic              flush_i;
    logic              hold_flag_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [STRB_W-1:0] mem_wstrb_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wstrb_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  flush_i,
        output hold_flag_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wstrb_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output flush_i,
        input  hold_flag_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch and load/store share one memory port, one transaction outstanding.
// Define MEM_ARB_STARVE_EN to force a fetch through after STARVE_MAX contested LS wins.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_LS = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              we_q, we_d;
    logic              drop_q, drop_d;
    logic              quiet_q;

    logic quiet, arb_en, pick_ls, if_gnt, ls_gnt, complete, if_rvalid, ls_rvalid;

    // Outputs stay silent during reset and the cycle after it.
    assign quiet  = rst | quiet_q;
    assign arb_en = !quiet && (state_q == S_IDLE);

`ifdef MEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starved;

    assign starved = bus.if_req_i && (cnt_q == CNT_W'(STARVE_MAX));
    assign pick_ls = bus.ls_req_i && !starved;

    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt)
            cnt_d = '0;
        else if (ls_gnt && bus.if_req_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic [31:0] starve_max_unused;
    assign starve_max_unused = 32'(STARVE_MAX);
    assign pick_ls = bus.ls_req_i;
`endif

    assign ls_gnt = arb_en && pick_ls;
    assign if_gnt = arb_en && bus.if_req_i && !pick_ls;

    // A response counts in REQ only together with the grant, otherwise only in WAIT.
    assign complete  = !quiet && bus.mem_rvalid_i &&
                       (((state_q == S_REQ) && bus.mem_gnt_i) || (state_q == S_WAIT));
    assign if_rvalid = complete && (owner_q == OWN_IF) && !(drop_q || bus.flush_i);
    assign ls_rvalid = complete && (owner_q == OWN_LS);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (ls_gnt || if_gnt) begin
                    state_d = S_REQ;
                    owner_d = ls_gnt ? OWN_LS : OWN_IF;
                    addr_d  = ls_gnt ? bus.ls_addr_i : bus.if_addr_i;
                    wdata_d = ls_gnt ? bus.ls_wdata_i : '0;
                    wstrb_d = ls_gnt ? bus.ls_wstrb_i : '0;
                    we_d    = ls_gnt && bus.ls_we_i;
                    drop_d  = 1'b0;
                end
            end
            S_REQ: begin
                if (bus.mem_gnt_i)
                    state_d = bus.mem_rvalid_i ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rvalid_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && (owner_q == OWN_IF) && bus.flush_i)
            drop_d = 1'b1;
        if (complete)
            drop_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
            quiet_q <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            drop_q  <= drop_d;
            quiet_q <= 1'b0;
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.ls_gnt_o    = ls_gnt;
    assign bus.if_rvalid_o = if_rvalid;
    assign bus.ls_rvalid_o = ls_rvalid;
    assign bus.if_rdata_o  = quiet ? '0 : bus.mem_rdata_i;
    assign bus.ls_rdata_o  = quiet ? '0 : bus.mem_rdata_i;

    assign bus.hold_flag_o = !quiet &&
                             ((bus.ls_req_i && !ls_gnt) ||
                              ((owner_q == OWN_LS) && (state_q != S_IDLE) && !ls_rvalid));

    // Fetch transactions can never write: we/strobes are gated by owner.
    assign bus.mem_req_o   = !quiet && (state_q == S_REQ);
    assign bus.mem_we_o    = !quiet && (owner_q == OWN_LS) && we_q;
    assign bus.mem_addr_o  = quiet ? '0 : addr_q;
    assign bus.mem_wdata_o = quiet ? '0 : wdata_q;
    assign bus.mem_wstrb_o = (quiet || (owner_q == OWN_IF)) ? '0 : wstrb_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the RV64_CPU core. Instruction fetch and load/store share one memory port through this block, with at most one transaction outstanding. It sequences each access as grant, then memory request, then response, and routes the response back to the requester that owns the transaction. It drives a hold flag into `ctrl` so the pipeline freezes while a load/store is pending, and it discards stale fetch responses when a jump flushes the front end.

## Interface
Parameters:
- `ADDR_W`, 32: address width for both requesters and the memory port.
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 4: number of consecutive contested arbitrations the LSU may win before the IF requester is forced through. Used only with `MEM_ARB_STARVE_EN`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `if_req_i` in 1: fetch request. Held, with the address stable, until `if_gnt_o`.
- `if_addr_i` in `ADDR_W`: fetch address.
- `if_gnt_o` out 1: one-cycle pulse; the fetch request is accepted in this cycle.
- `if_rvalid_o` out 1: fetch data valid.
- `if_rdata_o` out `DATA_W`: fetch data.
- `ls_req_i`, `ls_we_i` in 1: LSU request and write enable. Held stable until `ls_gnt_o`.
- `ls_addr_i` in `ADDR_W`: LSU address.
- `ls_wdata_i` in `DATA_W`: LSU write data.
- `ls_wstrb_i` in `DATA_W/8`: LSU byte strobes.
- `ls_gnt_o`, `ls_rvalid_o` out 1: LSU grant pulse and response valid. `ls_rvalid_o` acknowledges writes as well as reads.
- `ls_rdata_o` out `DATA_W`: load data.
- `flush_i` in 1: jump/flush from `ctrl`.
- `hold_flag_o` out 1: pipeline hold into `ctrl`.
- `mem_req_o`, `mem_we_o` out 1: memory request and write enable.
- `mem_addr_o` out `ADDR_W`: memory address.
- `mem_wdata_o` out `DATA_W`: memory write data.
- `mem_wstrb_o` out `DATA_W/8`: memory byte strobes.
- `mem_gnt_i` in 1: memory accepts the request.
- `mem_rvalid_i` in 1: memory response valid. Every transaction, read or write, returns exactly one.
- `mem_rdata_i` in `DATA_W`: memory read data.

## Operation
The state machine has three states: IDLE, REQ and WAIT. Registered state: owner (IF or LS), a latched request payload, a drop flag and a starvation counter.

- **IDLE**
  - Arbitrate among the active requests.
  - Default priority: LS wins over IF.
  - Pulse the winner's `*_gnt_o` combinationally in the same cycle.
  - Latch the winner's address, write data, strobes and write enable (the latter two are forced to 0 for IF), latch owner, then go to REQ.
  - With no request active, stay in IDLE.
- **REQ**
  - `mem_req_o`=1 and the `mem_*` outputs are driven from the latched payload.
  - On `mem_gnt_i`: if `mem_rvalid_i` is high in the same cycle, complete the transaction and go to IDLE; otherwise go to WAIT.
  - The request is never withdrawn before `mem_gnt_i`.
- **WAIT**
  - `mem_req_o`=0.
  - On `mem_rvalid_i`, complete the transaction and go to IDLE.
- **Completion**
  - Set the owner's `*_rvalid_o` = `mem_rvalid_i` for one cycle, combinationally.
  - `*_rdata_o` = `mem_rdata_i`.
  - Drive the non-owner's `rvalid` to 0.
- **Flush**
  - `flush_i` in REQ or WAIT with owner=IF sets the drop flag.
  - The transaction still completes on the memory side, but `if_rvalid_o` is suppressed on completion.
  - The drop flag clears when the transaction completes.
  - Flush never affects an LS transaction.
  - An `if_req_i` arriving in IDLE during a flush cycle is arbitrated normally; it carries the jump target.
- **hold_flag_o** = (`ls_req_i` & !`ls_gnt_o`) | (owner=LS & state≠IDLE & !`ls_rvalid_o`). This output is combinational.
- Writes on the IF path are impossible by construction: `mem_we_o`=0 and `mem_wstrb_o`=0 whenever owner=IF.

## Timing
- **Reset:** state IDLE, owner IF, drop 0, counter 0, payload registers 0. Every output is 0 in the reset cycle and in the cycle after it. Reset in mid-transaction abandons the transaction immediately with no response forwarded; the memory model must also be reset.
- **Minimum latency:**
  - request seen in IDLE at cycle N gives the grant pulse at N;
  - `mem_req_o` at N+1;
  - with `mem_gnt_i`=1 and `mem_rvalid_i`=1 at N+1, `*_rvalid_o` at N+1 and IDLE again at N+2;
  - back-to-back throughput is therefore one transaction per 2 cycles.
- A request dropped by its requester before grant is simply not serviced. Requesters must not drop a request before grant; the bench flags it as a protocol violation.
- `mem_rvalid_i` in IDLE, or in REQ without `mem_gnt_i`, is ignored.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - The counter increments on every IDLE arbitration where both requests are active and LS wins.
  - When the counter equals `STARVE_MAX`, the next contested arbitration goes to IF.
  - The counter clears whenever IF is granted.
- `MEM_ARB_STARVE_EN` undefined: strict LS priority with no counter logic.

## Test plan
- **Single fetch:** `if_req_i`=1, addr 0x80000000; memory grants at once and returns 0x00000013 one cycle later. Expect `if_gnt_o` at N, `mem_req_o` at N+1, `if_rvalid_o` with 0x13 at N+2.
- **Contention:** both requests active from reset release, LS being a write to 0x100 with strobe 0xF and data 0xDEADBEEF. Expect the LS grant first and `hold_flag_o`=1 until `ls_rvalid_o`, then the IF grant in the next IDLE.
- **Flush during a fetch:** `flush_i` pulsed while a fetch is in WAIT. Expect `if_rvalid_o` to stay 0 on `mem_rvalid_i`, and the next fetch to return data normally.
- **Zero-wait memory:** `mem_gnt_i` and `mem_rvalid_i` high in the same REQ cycle. Expect completion that cycle and a return to IDLE on the next.
- **Starvation, `MEM_ARB_STARVE_EN` defined:** LS requesting continuously, IF requesting continuously, `STARVE_MAX`=4. Expect 4 LS grants, then 1 IF grant, repeating. With the macro undefined, expect no IF grant at all.
- **Reset mid-WAIT:** assert `rst` for one cycle. Expect all outputs 0, and a fresh fetch to be granted normally afterwards.
